// File: rtl/ctrl_fsm_param_pkg.sv
// Shared types and constants for the multi-cycle CPU controller:
// state encoding, opcode map, ALU function codes, PC control and trap codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_BRANCH,
    ST_HALTED,
    ST_TRAP
  } state_t;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_MOVI = 5'h00;
  localparam opcode_t OP_MOV  = 5'h01;
  localparam opcode_t OP_ADDI = 5'h02;
  localparam opcode_t OP_ADD  = 5'h03;
  localparam opcode_t OP_SUB  = 5'h04;
  localparam opcode_t OP_AND  = 5'h05;
  localparam opcode_t OP_OR   = 5'h06;
  localparam opcode_t OP_JMP  = 5'h07;
  localparam opcode_t OP_SHL  = 5'h08;
  localparam opcode_t OP_SHR  = 5'h09;
  localparam opcode_t OP_ROR  = 5'h0A;
  localparam opcode_t OP_MUL  = 5'h0B;
  localparam opcode_t OP_XOR  = 5'h0C;
  localparam opcode_t OP_XORI = 5'h0D;
  localparam opcode_t OP_CMP  = 5'h0E;
  localparam opcode_t OP_CMPI = 5'h0F;
  localparam opcode_t OP_JZ   = 5'h10;
  localparam opcode_t OP_JC   = 5'h11;
  localparam opcode_t OP_HALT = 5'h12;

  typedef logic [3:0] alu_func_t;

  localparam alu_func_t ALU_PASS = 4'b0000;
  localparam alu_func_t ALU_ADD  = 4'b0001;
  localparam alu_func_t ALU_SUB  = 4'b0010;
  localparam alu_func_t ALU_AND  = 4'b0011;
  localparam alu_func_t ALU_OR   = 4'b0100;
  localparam alu_func_t ALU_SHL  = 4'b0101;
  localparam alu_func_t ALU_SHR  = 4'b0110;
  localparam alu_func_t ALU_MUL  = 4'b0111;
  localparam alu_func_t ALU_CMP  = 4'b1000;
  localparam alu_func_t ALU_ROR  = 4'b1001;
  localparam alu_func_t ALU_XOR  = 4'b1010;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // ALU operand select (0 immediate, 1 Rs) and function for one opcode
  typedef struct packed {
    logic      in_sel;
    alu_func_t func;
  } alu_ctl_t;

  function automatic alu_ctl_t alu_map(input opcode_t op);
    alu_ctl_t m;
    m.in_sel = 1'b1;
    m.func   = ALU_PASS;
    case (op)
      OP_MOVI: begin m.in_sel = 1'b0; m.func = ALU_PASS; end
      OP_MOV:  begin m.in_sel = 1'b1; m.func = ALU_PASS; end
      OP_ADDI: begin m.in_sel = 1'b0; m.func = ALU_ADD;  end
      OP_ADD:  begin m.in_sel = 1'b1; m.func = ALU_ADD;  end
      OP_SUB:  begin m.in_sel = 1'b1; m.func = ALU_SUB;  end
      OP_AND:  begin m.in_sel = 1'b1; m.func = ALU_AND;  end
      OP_OR:   begin m.in_sel = 1'b1; m.func = ALU_OR;   end
      OP_SHL:  begin m.in_sel = 1'b1; m.func = ALU_SHL;  end
      OP_SHR:  begin m.in_sel = 1'b1; m.func = ALU_SHR;  end
      OP_ROR:  begin m.in_sel = 1'b1; m.func = ALU_ROR;  end
      OP_MUL:  begin m.in_sel = 1'b1; m.func = ALU_MUL;  end
      OP_XOR:  begin m.in_sel = 1'b1; m.func = ALU_XOR;  end
      OP_XORI: begin m.in_sel = 1'b0; m.func = ALU_XOR;  end
      OP_CMP:  begin m.in_sel = 1'b1; m.func = ALU_CMP;  end
      OP_CMPI: begin m.in_sel = 1'b0; m.func = ALU_CMP;  end
      default: begin m.in_sel = 1'b1; m.func = ALU_PASS; end
    endcase
    return m;
  endfunction

  // Compare-only instructions update flags but skip write-back
  function automatic logic is_cmp(input opcode_t op);
    return (op == OP_CMP) || (op == OP_CMPI);
  endfunction

endpackage

// File: rtl/ctrl_fsm_param_if.sv
// Handshake and control bus between the datapath and the controller.
// The master side (datapath) drives instruction/ALU status; the slave
// side (controller) drives strobes, enables and status.
interface ctrl_fsm_param_if #(
  parameter int NUM_REGS   = 4,
  parameter int RD_W       = 2,
  parameter int OPC_W      = 5,
  parameter int ALU_FUNC_W = 4
);
  logic                  start;
  logic                  ir_valid;
  logic                  alu_done;
  logic [OPC_W-1:0]      opcode;
  logic [RD_W-1:0]       rd;
  logic                  alu_z;
  logic                  alu_c;

  logic                  fetch_pulse;
  logic                  pc_pulse;
  logic [1:0]            pc_ctrl;
  logic                  rf_pulse;
  logic [NUM_REGS-1:0]   reg_en;
  logic                  alu_in_sel;
  logic [ALU_FUNC_W-1:0] alu_func;
  logic                  busy;
  logic                  halted;
  logic                  trap;
  logic [1:0]            trap_code;

  modport master (
    output start, ir_valid, alu_done, opcode, rd, alu_z, alu_c,
    input  fetch_pulse, pc_pulse, pc_ctrl, rf_pulse, reg_en,
           alu_in_sel, alu_func, busy, halted, trap, trap_code
  );

  modport slave (
    input  start, ir_valid, alu_done, opcode, rd, alu_z, alu_c,
    output fetch_pulse, pc_pulse, pc_ctrl, rf_pulse, reg_en,
           alu_in_sel, alu_func, busy, halted, trap, trap_code
  );
endinterface

// File: rtl/ctrl_fsm_param_watchdog.sv
// EXEC-phase wait counter. Cleared outside EXEC; expire is high during
// the TIMEOUT_CYC-th consecutive enabled cycle, so the caller can still
// let a same-cycle alu_done take priority over the timeout.
module ctrl_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count;

  assign expire = (count == CNT_W'(TIMEOUT_CYC - 1));

  // count enabled cycles, saturating at the expiry value
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ctrl_fsm_param.sv
// Multi-cycle CPU controller: FETCH -> DECODE -> EXEC -> WB with branch,
// halt and trap handling. All outputs are registered and every strobe is
// a single-cycle pulse issued on entry to its state.
module ctrl_fsm_param
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 4,
  parameter int RD_W        = 2,
  parameter int OPC_W       = 5,
  parameter int ALU_FUNC_W  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_fsm_param_if.slave  bus
);

  state_t                state;
  logic                  z_flag;
  logic                  c_flag;
  logic                  cmp_op;

  logic                  fetch_pulse;
  logic                  pc_pulse;
  logic [1:0]            pc_ctrl;
  logic                  rf_pulse;
  logic [NUM_REGS-1:0]   reg_en;
  logic                  alu_in_sel;
  logic [ALU_FUNC_W-1:0] alu_func;
  logic                  busy;
  logic                  halted;
  logic                  trap;
  logic [1:0]            trap_code;

  opcode_t               op5;
  logic                  hi_zero;
  logic                  is_alu;
  logic                  is_branch;
  logic                  is_halt;
  logic                  taken;
  alu_ctl_t              alu_ctl;
  logic                  wd_expire;

  // Opcode classification; any set bit above the 5-bit field is illegal
  assign op5       = bus.opcode[4:0];
  assign hi_zero   = ((bus.opcode >> 5) == '0);
  assign is_alu    = hi_zero && !op5[4] && (op5 != OP_JMP);
  assign is_branch = hi_zero && ((op5 == OP_JMP) || (op5 == OP_JZ) || (op5 == OP_JC));
  assign is_halt   = hi_zero && (op5 == OP_HALT);
  assign taken     = (op5 == OP_JMP) || ((op5 == OP_JZ) && z_flag) || ((op5 == OP_JC) && c_flag);
  assign alu_ctl   = alu_map(op5);

  ctrl_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_EXEC),
    .enable (state == ST_EXEC),
    .expire (wd_expire)
  );

  // Controller FSM with registered outputs; pulses default low each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      z_flag      <= 1'b0;
      c_flag      <= 1'b0;
      cmp_op      <= 1'b0;
      fetch_pulse <= 1'b0;
      pc_pulse    <= 1'b0;
      pc_ctrl     <= PC_HOLD;
      rf_pulse    <= 1'b0;
      reg_en      <= '0;
      alu_in_sel  <= 1'b0;
      alu_func    <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      trap        <= 1'b0;
      trap_code   <= TRAP_NONE;
    end else begin
      fetch_pulse <= 1'b0;
      pc_pulse    <= 1'b0;
      pc_ctrl     <= PC_HOLD;
      rf_pulse    <= 1'b0;
      reg_en      <= '0;
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (bus.start) begin
            state       <= ST_FETCH;
            fetch_pulse <= 1'b1;
            pc_pulse    <= 1'b1;
            pc_ctrl     <= PC_INC;
            busy        <= 1'b1;
            halted      <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (bus.ir_valid) begin
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_alu) begin
            state      <= ST_EXEC;
            rf_pulse   <= 1'b1;
            alu_in_sel <= alu_ctl.in_sel;
            alu_func   <= ALU_FUNC_W'(alu_ctl.func);
            cmp_op     <= is_cmp(op5);
          end else if (is_branch) begin
            state    <= ST_BRANCH;
            pc_pulse <= taken;
            pc_ctrl  <= taken ? PC_LOAD : PC_HOLD;
          end else if (is_halt) begin
            state  <= ST_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state     <= ST_TRAP;
            busy      <= 1'b0;
            trap      <= 1'b1;
            trap_code <= TRAP_ILLEGAL;
          end
        end
        ST_EXEC: begin
          if (bus.alu_done) begin
            z_flag <= bus.alu_z;
            c_flag <= bus.alu_c;
            if (cmp_op) begin
              state       <= ST_FETCH;
              fetch_pulse <= 1'b1;
              pc_pulse    <= 1'b1;
              pc_ctrl     <= PC_INC;
            end else begin
              state  <= ST_WB;
              reg_en <= NUM_REGS'(1) << bus.rd;
            end
          end else if (wd_expire) begin
            state     <= ST_TRAP;
            busy      <= 1'b0;
            trap      <= 1'b1;
            trap_code <= TRAP_TIMEOUT;
          end
        end
        ST_WB, ST_BRANCH: begin
          state       <= ST_FETCH;
          fetch_pulse <= 1'b1;
          pc_pulse    <= 1'b1;
          pc_ctrl     <= PC_INC;
        end
        ST_TRAP: begin
          state <= ST_TRAP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.fetch_pulse = fetch_pulse;
  assign bus.pc_pulse    = pc_pulse;
  assign bus.pc_ctrl     = pc_ctrl;
  assign bus.rf_pulse    = rf_pulse;
  assign bus.reg_en      = reg_en;
  assign bus.alu_in_sel  = alu_in_sel;
  assign bus.alu_func    = alu_func;
  assign bus.busy        = busy;
  assign bus.halted      = halted;
  assign bus.trap        = trap;
  assign bus.trap_code   = trap_code;

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Directed, table-driven bench for ctrl_fsm_param (8 registers, timeout 4).
// Each vector drives one cycle of inputs and compares all outputs #1 after
// the following clock edge.
module tb_ctrl_fsm_param;
  import ctrl_pkg::*;

  localparam int NUM_REGS    = 8;
  localparam int RD_W        = 3;
  localparam int OPC_W       = 5;
  localparam int ALU_FUNC_W  = 4;
  localparam int TIMEOUT_CYC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ctrl_fsm_param_if #(
    .NUM_REGS   (NUM_REGS),
    .RD_W       (RD_W),
    .OPC_W      (OPC_W),
    .ALU_FUNC_W (ALU_FUNC_W)
  ) bus ();

  ctrl_fsm_param #(
    .NUM_REGS    (NUM_REGS),
    .RD_W        (RD_W),
    .OPC_W       (OPC_W),
    .ALU_FUNC_W  (ALU_FUNC_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       ir_valid;
    logic       alu_done;
    logic [4:0] opcode;
    logic [2:0] rd;
    logic       alu_z;
    logic       alu_c;
  } in_t;

  typedef struct packed {
    logic       fetch_pulse;
    logic       pc_pulse;
    logic [1:0] pc_ctrl;
    logic       rf_pulse;
    logic [7:0] reg_en;
    logic       alu_in_sel;
    logic [3:0] alu_func;
    logic       busy;
    logic       halted;
    logic       trap;
    logic [1:0] trap_code;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  int   vectors    = 0;
  int   miscompares = 0;

  function automatic in_t mi(logic r, logic s, logic iv, logic ad,
                             logic [4:0] op, logic [2:0] d, logic z, logic c);
    in_t t;
    t.rst = r; t.start = s; t.ir_valid = iv; t.alu_done = ad;
    t.opcode = op; t.rd = d; t.alu_z = z; t.alu_c = c;
    return t;
  endfunction

  function automatic out_t mo(logic fp, logic pp, logic [1:0] pcc, logic rf,
                              logic [7:0] re, logic sel, logic [3:0] fn,
                              logic bsy, logic hlt, logic trp, logic [1:0] tc);
    out_t o;
    o.fetch_pulse = fp; o.pc_pulse = pp; o.pc_ctrl = pcc; o.rf_pulse = rf;
    o.reg_en = re; o.alu_in_sel = sel; o.alu_func = fn;
    o.busy = bsy; o.halted = hlt; o.trap = trp; o.trap_code = tc;
    return o;
  endfunction

  function automatic vec_t mv(in_t s, out_t e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.fetch_pulse = bus.fetch_pulse; o.pc_pulse = bus.pc_pulse;
    o.pc_ctrl = bus.pc_ctrl; o.rf_pulse = bus.rf_pulse; o.reg_en = bus.reg_en;
    o.alu_in_sel = bus.alu_in_sel; o.alu_func = bus.alu_func;
    o.busy = bus.busy; o.halted = bus.halted; o.trap = bus.trap;
    o.trap_code = bus.trap_code;
    return o;
  endfunction

  task automatic drive(input in_t s);
    rst          = s.rst;
    bus.start    = s.start;
    bus.ir_valid = s.ir_valid;
    bus.alu_done = s.alu_done;
    bus.opcode   = s.opcode;
    bus.rd       = s.rd;
    bus.alu_z    = s.alu_z;
    bus.alu_c    = s.alu_c;
  endtask

  // apply one cycle of inputs, then compare every output after the edge
  task automatic step(input string name, input in_t s, input out_t e);
    out_t got;
    drive(s);
    @(posedge clk);
    #1;
    got = sample();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s: outputs got=%h required=%h", name, got, e);
    end else begin
      $display("vec %s: in=%h out=%h ok", name, s, got);
    end
  endtask

  initial begin
    drive(mi(1, 0, 0, 0, 5'h00, 3'd0, 0, 0));

    // reset, enter EXEC, then reset mid-instruction
    vecs.push_back(mv(mi(1,0,0,0,5'h00,3'd0,0,0), mo(0,0,2'b00,0,8'h00,0,4'h0,0,0,0,2'b00)));
    vecs.push_back(mv(mi(0,1,0,0,5'h00,3'd0,0,0), mo(1,1,2'b01,0,8'h00,0,4'h0,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,1,0,5'h03,3'd2,0,0), mo(0,0,2'b00,0,8'h00,0,4'h0,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h03,3'd2,0,0), mo(0,0,2'b00,1,8'h00,1,4'h1,1,0,0,2'b00)));
    vecs.push_back(mv(mi(1,0,0,0,5'h03,3'd2,0,0), mo(0,0,2'b00,0,8'h00,0,4'h0,0,0,0,2'b00)));
    // ADD r2, done on 2nd EXEC cycle
    vecs.push_back(mv(mi(0,1,0,0,5'h03,3'd2,0,0), mo(1,1,2'b01,0,8'h00,0,4'h0,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,1,0,5'h03,3'd2,0,0), mo(0,0,2'b00,0,8'h00,0,4'h0,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h03,3'd2,0,0), mo(0,0,2'b00,1,8'h00,1,4'h1,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h03,3'd2,0,0), mo(0,0,2'b00,0,8'h00,1,4'h1,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,1,5'h03,3'd2,0,0), mo(0,0,2'b00,0,8'h04,1,4'h1,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h03,3'd2,0,0), mo(1,1,2'b01,0,8'h00,1,4'h1,1,0,0,2'b00)));
    // ADDI r7: immediate operand, top register enable
    vecs.push_back(mv(mi(0,0,1,0,5'h02,3'd7,0,0), mo(0,0,2'b00,0,8'h00,1,4'h1,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h02,3'd7,0,0), mo(0,0,2'b00,1,8'h00,0,4'h1,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,1,5'h02,3'd7,0,0), mo(0,0,2'b00,0,8'h80,0,4'h1,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h02,3'd7,0,0), mo(1,1,2'b01,0,8'h00,0,4'h1,1,0,0,2'b00)));
    // CMP sets Z=1, straight back to FETCH; JZ taken
    vecs.push_back(mv(mi(0,0,1,0,5'h0E,3'd0,0,0), mo(0,0,2'b00,0,8'h00,0,4'h1,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h0E,3'd0,0,0), mo(0,0,2'b00,1,8'h00,1,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,1,5'h0E,3'd0,1,0), mo(1,1,2'b01,0,8'h00,1,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,1,0,5'h10,3'd0,0,0), mo(0,0,2'b00,0,8'h00,1,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h10,3'd0,0,0), mo(0,1,2'b10,0,8'h00,1,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h10,3'd0,0,0), mo(1,1,2'b01,0,8'h00,1,4'h8,1,0,0,2'b00)));
    // CMP sets Z=0; JZ not taken
    vecs.push_back(mv(mi(0,0,1,0,5'h0E,3'd0,0,0), mo(0,0,2'b00,0,8'h00,1,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h0E,3'd0,0,0), mo(0,0,2'b00,1,8'h00,1,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,1,5'h0E,3'd0,0,0), mo(1,1,2'b01,0,8'h00,1,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,1,0,5'h10,3'd0,0,0), mo(0,0,2'b00,0,8'h00,1,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h10,3'd0,0,0), mo(0,0,2'b00,0,8'h00,1,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h10,3'd0,0,0), mo(1,1,2'b01,0,8'h00,1,4'h8,1,0,0,2'b00)));
    // CMPI sets C=1; JC taken
    vecs.push_back(mv(mi(0,0,1,0,5'h0F,3'd0,0,0), mo(0,0,2'b00,0,8'h00,1,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h0F,3'd0,0,0), mo(0,0,2'b00,1,8'h00,0,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,1,5'h0F,3'd0,0,1), mo(1,1,2'b01,0,8'h00,0,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,1,0,5'h11,3'd0,0,0), mo(0,0,2'b00,0,8'h00,0,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h11,3'd0,0,0), mo(0,1,2'b10,0,8'h00,0,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h11,3'd0,0,0), mo(1,1,2'b01,0,8'h00,0,4'h8,1,0,0,2'b00)));
    // HALT, wait, restart with start
    vecs.push_back(mv(mi(0,0,1,0,5'h12,3'd0,0,0), mo(0,0,2'b00,0,8'h00,0,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h12,3'd0,0,0), mo(0,0,2'b00,0,8'h00,0,4'h8,0,1,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h12,3'd0,0,0), mo(0,0,2'b00,0,8'h00,0,4'h8,0,1,0,2'b00)));
    vecs.push_back(mv(mi(0,1,0,0,5'h12,3'd0,0,0), mo(1,1,2'b01,0,8'h00,0,4'h8,1,0,0,2'b00)));
    // illegal opcode traps; start ignored; rst clears
    vecs.push_back(mv(mi(0,0,1,0,5'h1F,3'd0,0,0), mo(0,0,2'b00,0,8'h00,0,4'h8,1,0,0,2'b00)));
    vecs.push_back(mv(mi(0,0,0,0,5'h1F,3'd0,0,0), mo(0,0,2'b00,0,8'h00,0,4'h8,0,0,1,2'b01)));
    vecs.push_back(mv(mi(0,1,1,0,5'h1F,3'd0,0,0), mo(0,0,2'b00,0,8'h00,0,4'h8,0,0,1,2'b01)));
    vecs.push_back(mv(mi(1,0,0,0,5'h00,3'd0,0,0), mo(0,0,2'b00,0,8'h00,0,4'h0,0,0,0,2'b00)));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("tbl%0d", i), vecs[i].stim, vecs[i].exp);
    end

    // ALU timeout: no alu_done for 4 EXEC cycles -> trap code 10
    step("to_fetch",  mi(0,1,0,0,5'h03,3'd5,0,0), mo(1,1,2'b01,0,8'h00,0,4'h0,1,0,0,2'b00));
    step("to_decode", mi(0,0,1,0,5'h03,3'd5,0,0), mo(0,0,2'b00,0,8'h00,0,4'h0,1,0,0,2'b00));
    step("to_exec",   mi(0,0,0,0,5'h03,3'd5,0,0), mo(0,0,2'b00,1,8'h00,1,4'h1,1,0,0,2'b00));
    for (int k = 1; k <= 3; k++) begin
      step($sformatf("to_wait%0d", k), mi(0,0,0,0,5'h03,3'd5,0,0),
           mo(0,0,2'b00,0,8'h00,1,4'h1,1,0,0,2'b00));
    end
    step("to_trap",   mi(0,0,0,0,5'h03,3'd5,0,0), mo(0,0,2'b00,0,8'h00,1,4'h1,0,0,1,2'b10));
    step("to_start",  mi(0,1,0,0,5'h03,3'd5,0,0), mo(0,0,2'b00,0,8'h00,1,4'h1,0,0,1,2'b10));
    step("to_rst",    mi(1,0,0,0,5'h03,3'd5,0,0), mo(0,0,2'b00,0,8'h00,0,4'h0,0,0,0,2'b00));

    // alu_done arriving in the expiring cycle wins -> normal write-back
    step("late_fetch",  mi(0,1,0,0,5'h03,3'd5,0,0), mo(1,1,2'b01,0,8'h00,0,4'h0,1,0,0,2'b00));
    step("late_decode", mi(0,0,1,0,5'h03,3'd5,0,0), mo(0,0,2'b00,0,8'h00,0,4'h0,1,0,0,2'b00));
    step("late_exec",   mi(0,0,0,0,5'h03,3'd5,0,0), mo(0,0,2'b00,1,8'h00,1,4'h1,1,0,0,2'b00));
    for (int k = 1; k <= 3; k++) begin
      step($sformatf("late_wait%0d", k), mi(0,0,0,0,5'h03,3'd5,0,0),
           mo(0,0,2'b00,0,8'h00,1,4'h1,1,0,0,2'b00));
    end
    step("late_wb",     mi(0,0,0,1,5'h03,3'd5,0,1), mo(0,0,2'b00,0,8'h20,1,4'h1,1,0,0,2'b00));
    step("late_refetch",mi(0,0,0,0,5'h03,3'd5,0,0), mo(1,1,2'b01,0,8'h00,1,4'h1,1,0,0,2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
